mem_bist_master: RTL
====================

MEM_BIST_MASTER -- requirements
Module: mem_bist_master

Interface
REQ-001 Parameter WIDTH, default 16, memory data width in bits.
REQ-002 Parameter DEPTH, default 16, number of memory words tested.
REQ-003 Parameter ADDRWIDTH, default $clog2(DEPTH), memory address width.
REQ-004 Parameter TIMEOUT, default 15, maximum cycles valid_o may wait for ready_i.
REQ-005 The block has one clock; reset is synchronous and active-high: clk_i in 1, rising-edge clock; rst_i in 1, synchronous active-high reset.
REQ-006 Control ports: start_i in 1 (run request); pattern_sel_i in 2 (pattern code); busy_o out 1; done_o out 1 (one-cycle pulse); pass_o out 1; timeout_o out 1; err_count_o out ADDRWIDTH+1.
REQ-007 Memory-side ports: addr_o out ADDRWIDTH; wdata_o out WIDTH; valid_o out 1; wr_en_o out 1; rd_en_o out 1; rdata_i in WIDTH; ready_i in 1.
REQ-008 Error-log ports: err_addr_o out ADDRWIDTH; err_data_o out WIDTH (see REQ-026).

Function
REQ-009 FSM states: IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, FINISH.
REQ-010 IDLE: start_i=1 -> latch pattern_sel_i, clear err_count_o/pass_o/timeout_o, addr=0, go WR_REQ; busy_o=1 in every state except IDLE.
REQ-011 start_i is ignored in every state except IDLE.
REQ-012 Patterns by addr a: 0 all-zeros; 1 all-ones; 2 checkerboard (a even: 'hAAAA, a odd: 'h5555, truncated/replicated to WIDTH); 3 data = a, zero-extended.
REQ-013 WR_REQ: valid_o=1, wr_en_o=1, rd_en_o=0, addr_o=a, wdata_o=pattern(a), all held stable until ready_i=1 is sampled.
REQ-014 WR_REQ with ready_i=1 -> WR_GAP; WR_GAP drives valid_o=0 for exactly one cycle so the responder drops ready, then a=DEPTH-1 -> a=0, RD_REQ; else a+1, WR_REQ.
REQ-015 RD_REQ: valid_o=1, rd_en_o=1, wr_en_o=0, addr_o=a; on the cycle ready_i=1, compare rdata_i against pattern(a) and go RD_GAP.
REQ-016 Mismatch increments err_count_o, saturating at 2^(ADDRWIDTH+1)-1.
REQ-017 RD_GAP: valid_o=0 for one cycle, then a=DEPTH-1 -> FINISH; else a+1, RD_REQ.
REQ-018 Cost per word: 2 cycles minimum per write and per read (request + gap); a full zero-wait run takes 4*DEPTH+1 cycles from start to done_o.
REQ-019 Per-request wait counter: it resets on entry to WR_REQ/RD_REQ; if ready_i has stayed 0 for TIMEOUT cycles, set timeout_o=1 and go FINISH immediately, dropping valid_o.
REQ-020 FINISH: done_o=1 for one cycle; pass_o=1 iff err_count_o=0 and timeout_o=0; next state IDLE.
REQ-021 pass_o, timeout_o and err_count_o hold their values in IDLE until the next accepted start_i.
REQ-022 wr_en_o and rd_en_o are never both 1; both are 0 whenever valid_o=0.
REQ-023 ready_i=1 while valid_o=0 is ignored.

Reset
REQ-024 rst_i=1 at any clock edge, including mid-run, forces IDLE and sets every output to 0 (valid_o, wr_en_o, rd_en_o, addr_o, wdata_o, busy_o, done_o, pass_o, timeout_o, err_count_o, err_addr_o, err_data_o).
REQ-025 A run interrupted by reset produces no done_o pulse.

Configuration
REQ-026 Macro MEM_BIST_ERRLOG_EN defined: on the first mismatch of a run, capture a into err_addr_o and rdata_i into err_data_o; hold both until the next accepted start_i, which clears them.
REQ-027 Macro MEM_BIST_ERRLOG_EN undefined: err_addr_o and err_data_o are constant 0 and no capture registers exist.

Structure
REQ-028 Package mem_bist_pkg holds the FSM state enum, the pattern-code localparams (PAT_ZERO, PAT_ONES, PAT_CHECKER, PAT_ADDR) and the checkerboard constants.
REQ-029 Pattern generation lives in sub-module mem_bist_patgen (inputs: pattern code, address; output: WIDTH-bit data), instantiated once and shared by the write and compare paths.

Verification
REQ-030 Pairing with a zero-wait memory responder, pattern 3, DEPTH=16 -> memory holds mem[a]=a; done_o at cycle 65 after start; pass_o=1; err_count_o=0.
REQ-031 Responder forced to return 'h0000 at address 5, pattern 1 -> err_count_o=1; pass_o=0; with MEM_BIST_ERRLOG_EN: err_addr_o=5, err_data_o='h0000.
REQ-032 Stuck-low ready_i, TIMEOUT=15 -> valid_o falls after 15 wait cycles; timeout_o=1; done_o pulses; pass_o=0; addr_o=0.
REQ-033 rst_i pulsed during RD_REQ at address 9 -> next cycle all outputs are 0 and busy_o=0; no done_o pulse; a following start_i runs a full clean pass.
REQ-034 start_i held high throughout a run -> exactly one run per IDLE visit; on every cycle, wr_en_o&rd_en_o=0 and valid_o=0 implies both enables are 0.
REQ-035 Pattern 2 with 3-cycle ready latency per request -> even addresses 'hAAAA, odd 'h5555; all request signals stable while waiting; pass_o=1.

Source files
------------

// File: rtl/mem_bist_pkg.sv
// mem_bist_pkg: shared FSM states, pattern codes and checkerboard constants
// for the memory BIST master.
package mem_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_GAP,
        RD_REQ,
        RD_GAP,
        FINISH
    } state_t;

    localparam logic [1:0] PAT_ZERO    = 2'd0;
    localparam logic [1:0] PAT_ONES    = 2'd1;
    localparam logic [1:0] PAT_CHECKER = 2'd2;
    localparam logic [1:0] PAT_ADDR    = 2'd3;

    localparam logic [15:0] CHECKER_EVEN = 16'hAAAA;
    localparam logic [15:0] CHECKER_ODD  = 16'h5555;

endpackage

// File: rtl/mem_bist_patgen.sv
// mem_bist_patgen: expected/write data for a pattern code at an address;
// checkerboard words repeat every 16 bits so any WIDTH is covered.
module mem_bist_patgen
    import mem_bist_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ADDRWIDTH = 4
) (
    input  logic [1:0]           pattern_i,
    input  logic [ADDRWIDTH-1:0] addr_i,
    output logic [WIDTH-1:0]     data_o
);

    logic [WIDTH-1:0] even_w;
    logic [WIDTH-1:0] odd_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chk
        assign even_w[i] = CHECKER_EVEN[i % 16];
        assign odd_w[i]  = CHECKER_ODD[i % 16];
    end

    always_comb
        data_o = (pattern_i == PAT_ZERO)    ? '0 :
                 (pattern_i == PAT_ONES)    ? '1 :
                 (pattern_i == PAT_CHECKER) ? (addr_i[0] ? odd_w : even_w) :
                                              WIDTH'(addr_i);

endmodule

// File: rtl/mem_bist_master.sv
// mem_bist_master: write-then-read-compare BIST over DEPTH words with a
// per-request ready timeout; define MEM_BIST_ERRLOG_EN to log the first mismatch.
module mem_bist_master
    import mem_bist_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 16,
    parameter int ADDRWIDTH = $clog2(DEPTH),
    parameter int TIMEOUT   = 15
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [1:0]           pattern_sel_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic                 timeout_o,
    output logic [ADDRWIDTH:0]   err_count_o,
    output logic [ADDRWIDTH-1:0] addr_o,
    output logic [WIDTH-1:0]     wdata_o,
    output logic                 valid_o,
    output logic                 wr_en_o,
    output logic                 rd_en_o,
    input  logic [WIDTH-1:0]     rdata_i,
    input  logic                 ready_i,
    output logic [ADDRWIDTH-1:0] err_addr_o,
    output logic [WIDTH-1:0]     err_data_o
);

    localparam int                   TW      = $clog2(TIMEOUT + 1);
    localparam logic [ADDRWIDTH-1:0] LAST    = ADDRWIDTH'(DEPTH - 1);
    localparam logic [ADDRWIDTH:0]   ERR_MAX = '1;

    state_t               state;
    state_t               state_next;
    logic [1:0]           pat_q;
    logic [ADDRWIDTH-1:0] a_q;
    logic [TW-1:0]        wait_q;
    logic [ADDRWIDTH:0]   err_q;
    logic                 pass_q;
    logic                 to_q;
    logic [WIDTH-1:0]     pat_data;
    logic                 req;
    logic                 wait_exp;
    logic                 mismatch;
    logic                 ok;
    logic                 accept;

    mem_bist_patgen #(
        .WIDTH    (WIDTH),
        .ADDRWIDTH(ADDRWIDTH)
    ) u_patgen (
        .pattern_i(pat_q),
        .addr_i   (a_q),
        .data_o   (pat_data)
    );

    assign req      = (state == WR_REQ) || (state == RD_REQ);
    assign accept   = (state == IDLE) && start_i;
    assign wait_exp = req && !ready_i && (wait_q == TW'(TIMEOUT - 1));
    assign mismatch = (state == RD_REQ) && ready_i && (rdata_i != pat_data);
    assign ok       = (err_q == '0) && !to_q;

    always_ff @(posedge clk_i)
        if (rst_i) state <= IDLE;
        else       state <= state_next;

    always_comb begin
        state_next = state;
        busy_o     = 1'b1;
        done_o     = 1'b0;
        pass_o     = pass_q;
        valid_o    = 1'b0;
        wr_en_o    = 1'b0;
        rd_en_o    = 1'b0;
        addr_o     = '0;
        wdata_o    = '0;
        case (state)
            IDLE: begin
                busy_o     = 1'b0;
                state_next = start_i ? WR_REQ : IDLE;
            end
            WR_REQ: begin
                valid_o    = 1'b1;
                wr_en_o    = 1'b1;
                addr_o     = a_q;
                wdata_o    = pat_data;
                state_next = ready_i ? WR_GAP : wait_exp ? FINISH : WR_REQ;
            end
            WR_GAP: state_next = (a_q == LAST) ? RD_REQ : WR_REQ;
            RD_REQ: begin
                valid_o    = 1'b1;
                rd_en_o    = 1'b1;
                addr_o     = a_q;
                state_next = ready_i ? RD_GAP : wait_exp ? FINISH : RD_REQ;
            end
            RD_GAP: state_next = (a_q == LAST) ? FINISH : RD_REQ;
            FINISH: begin
                done_o     = 1'b1;
                pass_o     = ok;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Error count and timeout are final by FINISH, so pass is latched there.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pat_q  <= PAT_ZERO;
            a_q    <= '0;
            wait_q <= '0;
            err_q  <= '0;
            pass_q <= 1'b0;
            to_q   <= 1'b0;
        end else begin
            wait_q <= (req && !ready_i) ? wait_q + 1'b1 : '0;
            if (accept) begin
                pat_q  <= pattern_sel_i;
                a_q    <= '0;
                err_q  <= '0;
                pass_q <= 1'b0;
                to_q   <= 1'b0;
            end
            if (state == WR_GAP || state == RD_GAP)
                a_q <= (a_q == LAST) ? '0 : a_q + 1'b1;
            if (mismatch && err_q != ERR_MAX)
                err_q <= err_q + 1'b1;
            if (wait_exp)
                to_q <= 1'b1;
            if (state == FINISH)
                pass_q <= ok;
        end
    end

    assign err_count_o = err_q;
    assign timeout_o   = to_q;

`ifdef MEM_BIST_ERRLOG_EN
    logic [ADDRWIDTH-1:0] err_addr_q;
    logic [WIDTH-1:0]     err_data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || accept) begin
            err_addr_q <= '0;
            err_data_q <= '0;
        end else if (mismatch && err_q == '0) begin
            err_addr_q <= a_q;
            err_data_q <= rdata_i;
        end
    end

    assign err_addr_o = err_addr_q;
    assign err_data_o = err_data_q;
`else
    assign err_addr_o = '0;
    assign err_data_o = '0;
`endif

endmodule
